// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the connection-block configuration loader.
// Optional readback port set is controlled by macro CFG_READBACK_EN.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Number of DW-bit words needed to cover cfg_w configuration bits.
  function automatic int nwords(input int cfg_w, input int dw);
    return (cfg_w + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Word-addressed shadow register; exposes its next value so the committed
// copy can capture the final word in the same cycle it is accepted.
module cfg_shadow_reg #(
  parameter int DW     = 8,
  parameter int NWORDS = 31,
  parameter int IDX_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DW-1:0]          wr_data,
  output logic [NWORDS*DW-1:0]   shadow_nxt
);

  localparam int SW = NWORDS * DW;

  logic [SW-1:0] shadow_r;

  // Merge the incoming word into its slot; all other slots hold.
  always_comb begin
    shadow_nxt = shadow_r;
    for (int k = 0; k < NWORDS; k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        shadow_nxt[k*DW +: DW] = wr_data;
      end else begin
        shadow_nxt[k*DW +: DW] = shadow_r[k*DW +: DW];
      end
    end
  end

  // Shadow storage, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= {SW{1'b0}};
    end else begin
      shadow_r <= shadow_nxt;
    end
  end

endmodule

// File: rtl/cb_config_loader.sv
// Loads NWORDS configuration words into a shadow register and commits them
// atomically to the switch-control bus c. Readback option: CFG_READBACK_EN.
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int CFG_W = 248,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CFG_W-1:0] c,
  output logic             busy,
  output logic             done
`ifdef CFG_READBACK_EN
  ,
  output logic [DW-1:0]    rb_data,
  output logic             rb_valid
`endif
);

  localparam int NWORDS = nwords(CFG_W, DW);
  localparam int SW     = NWORDS * DW;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  cfg_state_e       state_r, state_n;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;
  logic             wr_en_s;
  logic             commit_s;
  logic             clr_cnt_s;
  logic [SW-1:0]    shadow_nxt_s;
  logic [CFG_W-1:0] c_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;

  assign last_s = (cnt_r == CNT_W'(NWORDS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state; abort outranks the final word so a colliding abort never commits.
  always_comb begin
    state_n   = state_r;
    wr_en_s   = 1'b0;
    commit_s  = 1'b0;
    clr_cnt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          clr_cnt_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
        end else if (in_valid) begin
          wr_en_s = 1'b1;
          if (last_s) begin
            state_n  = COMMIT;
            commit_s = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end else begin
          state_n = LOAD;
        end
      end
      COMMIT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (wr_en_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  cfg_shadow_reg #(
    .DW     (DW),
    .NWORDS (NWORDS),
    .IDX_W  (CNT_W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en_s),
    .wr_idx     (cnt_r),
    .wr_data    (in_data),
    .shadow_nxt (shadow_nxt_s)
  );

  // Committed bus captures the merged shadow on the final word; pad bits dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_r <= {CFG_W{1'b0}};
    end else if (commit_s) begin
      c_r <= shadow_nxt_s[CFG_W-1:0];
    end
  end

  // Status flags registered from the next state so they align with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= (state_n == LOAD);
      busy_r     <= (state_n == LOAD);
      done_r     <= (state_n == COMMIT);
    end
  end

  assign c        = c_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef CFG_READBACK_EN
  logic [SW-1:0] c_pad_s;
  logic [DW-1:0] rb_sel_s;
  logic [DW-1:0] rb_data_r;
  logic          rb_valid_r;

  // Zero-extend the committed bus to whole words.
  always_comb begin
    c_pad_s            = {SW{1'b0}};
    c_pad_s[CFG_W-1:0] = c_r;
  end

  // Pick the committed word matching the slot being written.
  always_comb begin
    rb_sel_s = {DW{1'b0}};
    for (int k = 0; k < NWORDS; k++) begin
      if (cnt_r == CNT_W'(k)) begin
        rb_sel_s = c_pad_s[k*DW +: DW];
      end else begin
        rb_sel_s = rb_sel_s;
      end
    end
  end

  // Readback register, one cycle behind the accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_valid_r <= 1'b0;
      rb_data_r  <= {DW{1'b0}};
    end else begin
      rb_valid_r <= wr_en_s;
      if (wr_en_s) begin
        rb_data_r <= rb_sel_s;
      end
    end
  end

  assign rb_data  = rb_data_r;
  assign rb_valid = rb_valid_r;
`endif

endmodule
